// File: rtl/icache_downstream_responder.sv
// ============================================================================
//  Module   : icache_downstream_responder
//  Function : Fixed-latency memory responder for icache linefill requests.
//             Queues requests and returns one cacheline per request.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module icache_downstream_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int TXNID_WIDTH     = 8,
  parameter int ENTRY_IDX_WIDTH = 3,
  parameter int OPCODE_WIDTH    = 2,
  parameter int REQ_FIFO_DEPTH  = 4,
  parameter int RSP_LATENCY     = 8,
  parameter int LINE_IDX_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       downstream_txreq_vld,
  output logic                       downstream_txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]      downstream_txreq_addr,
  input  logic [TXNID_WIDTH-1:0]     downstream_txreq_txnid,
  input  logic [ENTRY_IDX_WIDTH-1:0] downstream_txreq_entry_idx,
  input  logic [OPCODE_WIDTH-1:0]    downstream_txreq_opcode,
  output logic                       downstream_rxdat_vld,
  input  logic                       downstream_rxdat_rdy,
  output logic [DATA_WIDTH+TXNID_WIDTH+ENTRY_IDX_WIDTH+OPCODE_WIDTH-1:0] downstream_rxdat_pld,
  input  logic                       mem_wr_en,
  input  logic [LINE_IDX_WIDTH-1:0]  mem_wr_line_idx,
  input  logic [DATA_WIDTH-1:0]      mem_wr_data,
  output logic                       busy
);

  localparam int PTR_W  = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(REQ_FIFO_DEPTH + 1);
  localparam int LAT_W  = $clog2(RSP_LATENCY + 1);
  localparam int LINES  = 2 ** LINE_IDX_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAT_C   = LAT_W'(RSP_LATENCY);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      downstream_rxdat_data;
    logic [TXNID_WIDTH-1:0]     downstream_rxdat_txnid;
    logic [ENTRY_IDX_WIDTH-1:0] downstream_rxdat_entry_idx;
    logic [OPCODE_WIDTH-1:0]    downstream_rxdat_opcode;
  } downstream_rxdat_t;

  typedef struct packed {
    logic [LINE_IDX_WIDTH-1:0]  line;
    logic [TXNID_WIDTH-1:0]     txnid;
    logic [ENTRY_IDX_WIDTH-1:0] entry_idx;
    logic [OPCODE_WIDTH-1:0]    opcode;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LAT_W-1:0]  cnt;
  req_t              work;
  req_t              req_in;
  req_t              fifo_mem [REQ_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] store [LINES];
  downstream_rxdat_t pld;
  logic              push, pop, capture, handshake;

  // Only the line-index slice of the address selects a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{downstream_txreq_addr[ADDR_WIDTH-1:6+LINE_IDX_WIDTH],
                              downstream_txreq_addr[5:0]};

  assign req_in = '{line:      downstream_txreq_addr[6 +: LINE_IDX_WIDTH],
                    txnid:     downstream_txreq_txnid,
                    entry_idx: downstream_txreq_entry_idx,
                    opcode:    downstream_txreq_opcode};

  assign downstream_txreq_rdy = (count != DEPTH_C);
  assign push                 = downstream_txreq_vld && downstream_txreq_rdy;
  assign downstream_rxdat_pld = pld;
  assign busy                 = (count != '0) || (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (downstream_rxdat_rdy) begin
          handshake = 1'b1;
          if (count != '0) begin
            pop        = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      count                <= '0;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      cnt                  <= '0;
      work                 <= '0;
      pld                  <= '0;
      downstream_rxdat_vld <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop) begin
        work   <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
        cnt    <= LAT_C;
      end else if (state == WAIT) begin
        cnt <= cnt - LAT_W'(1);
      end
      // Store read here sees the pre-edge contents, so a same-edge preload is not visible.
      if (capture) begin
        pld <= '{downstream_rxdat_data:      store[work.line],
                 downstream_rxdat_txnid:     work.txnid,
                 downstream_rxdat_entry_idx: work.entry_idx,
                 downstream_rxdat_opcode:    work.opcode};
        downstream_rxdat_vld <= 1'b1;
      end else if (handshake) begin
        pld                  <= '0;
        downstream_rxdat_vld <= 1'b0;
      end
    end
  end

  // Storage arrays carry no reset; the backing store survives reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) store[mem_wr_line_idx] <= mem_wr_data;
  end

endmodule

`default_nettype wire
